// File: rtl/leon_arb_pkg.sv
// leon_arb_pkg: shared types and constants for the LEON memory arbiter
package leon_arb_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} arb_state_e;
   typedef enum logic {OWN_IC, OWN_DC} owner_e;
   localparam logic [31:0] NOP_INST = 32'h0100_0000;
endpackage

// File: rtl/leon_arb_timeout.sv
// leon_arb_timeout: per-access wait counter, flags when it reaches TIMEOUT-1
module leon_arb_timeout #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT);
   logic [W-1:0] cnt;
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/leon_mem_arbiter.sv
// leon_mem_arbiter: shares one memory port between icache fetches and dcache accesses
module leon_mem_arbiter
   import leon_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 16,
   parameter int STARVE_MAX = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [DATA_W-1:0] ic_rdata,
   output logic              ic_valid,
   output logic              ic_exc,
   output logic              ic_stall,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_valid,
   output logic              dc_mexc,
   output logic              dc_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   input  logic              mem_err
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   arb_state_e        state, state_n;
   owner_e            owner;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              we_q, err_q, expired, grant, pick_ic, resp;
   logic [SW-1:0]     starve;

   leon_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == IDLE),
      .en      (state == GRANT || state == WAIT),
      .expired (expired)
   );

   assign grant   = state == IDLE && (ic_req || dc_req);
   assign pick_ic = ic_req && (!dc_req || starve == SW'(STARVE_MAX));

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (ic_req || dc_req) state_n = GRANT;
         GRANT:   state_n = WAIT;
         WAIT:    if (mem_ack || expired) state_n = RESP;
         default: state_n = IDLE;
      endcase
      resp      = state == RESP;
      mem_req   = state == GRANT || state == WAIT;
      mem_we    = mem_req & we_q;
      mem_addr  = mem_req ? addr_q : '0;
      mem_wdata = mem_req ? wdata_q : '0;
      ic_valid  = resp && owner == OWN_IC && ic_req;
      dc_valid  = resp && owner == OWN_DC && dc_req;
      ic_rdata  = ic_valid ? rdata_q : '0;
      dc_rdata  = dc_valid ? rdata_q : '0;
      ic_exc    = ic_valid & err_q;
      dc_mexc   = dc_valid & err_q;
      ic_stall  = ic_req && !(resp && owner == OWN_IC);
      dc_stall  = dc_req && !(resp && owner == OWN_DC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         owner   <= OWN_IC;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         starve  <= '0;
      end else begin
         state <= state_n;
         if (grant) begin
            owner   <= pick_ic ? OWN_IC : OWN_DC;
            addr_q  <= pick_ic ? ic_addr : dc_addr;
            we_q    <= ~pick_ic & dc_we;
            wdata_q <= pick_ic ? '0 : dc_wdata;
         end
         // an ack in the expiry cycle takes precedence over the timeout
         if (state == WAIT && mem_ack) begin
            rdata_q <= (mem_err || we_q) ? '0 : mem_rdata;
            err_q   <= mem_err;
         end else if (state == WAIT && expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
         if (!ic_req || (grant && pick_ic)) starve <= '0;
         else if (grant && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
      end
   end
endmodule

// File: tb/tb_leon_mem_arbiter.sv
// tb_leon_mem_arbiter: directed and random checks of the arbiter against a timestamp-based transaction model
module tb_leon_mem_arbiter;
   import leon_arb_pkg::*;
   localparam int TIMEOUT = 16, STARVE_MAX = 2;

   logic clk = 1'b0, rst = 1'b1;
   logic ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, mem_ack, mem_err;
   logic [31:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0, mem_rdata;
   logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
   logic ic_valid, ic_exc, ic_stall, dc_valid, dc_mexc, dc_stall, mem_req, mem_we;

   leon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_valid(ic_valid), .ic_exc(ic_exc), .ic_stall(ic_stall),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_rdata(dc_rdata),
      .dc_valid(dc_valid), .dc_mexc(dc_mexc), .dc_stall(dc_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0, cyc_n = 0, n;
   int t_start, t_end, t_ack = -1, t_resp, next_free = 0, starve = 0, k_lat = 1, k_err = 0;
   bit act = 1'b0, own_dc, m_we, m_merr, m_exc, late_ack = 1'b0, k_rnd = 1'b0, ic_hold = 1'b0, dc_hold = 1'b0, prev;
   logic [31:0] m_addr, m_wdata, m_raw, m_data, k_raw = '0;
   logic [31:0] ga [3];
   int g;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // memory responder plus transaction prediction for the cycle whose inputs were just driven
   task automatic commit();
      int lat, sel;
      bit err;
      mem_ack   = (act && cyc_n == t_ack) || late_ack;
      mem_err   = act && cyc_n == t_ack && m_merr;
      mem_rdata = (act && cyc_n == t_ack) ? m_raw : NOP_INST;
      late_ack  = 1'b0;
      if (rst) begin
         act = 1'b0;
         starve = 0;
         next_free = cyc_n + 1;
      end else if (!act && cyc_n >= next_free && (ic_req || dc_req)) begin
         own_dc  = dc_req && !(ic_req && starve == STARVE_MAX);
         m_addr  = own_dc ? dc_addr : ic_addr;
         m_we    = own_dc && dc_we;
         m_wdata = dc_wdata;
         lat = k_lat; err = k_err != 0; m_raw = k_raw;
         if (k_rnd) begin
            sel = $urandom_range(0, 5);
            lat = sel == 5 ? 0 : sel == 4 ? TIMEOUT - 1 : sel + 1;
            err = $urandom_range(0, 4) == 0;
            m_raw = $urandom;
         end
         m_merr  = err;
         t_start = cyc_n + 1;
         t_ack   = lat > 0 ? t_start + lat : -1;
         t_end   = lat > 0 ? t_ack : t_start + TIMEOUT - 1;
         t_resp  = t_end + 1;
         next_free = t_resp + 1;
         m_exc   = lat == 0 || err;
         m_data  = (m_exc || m_we) ? 32'h0 : m_raw;
         act     = 1'b1;
         starve  = (!ic_req || !own_dc) ? 0 : (starve < STARVE_MAX ? starve + 1 : starve);
      end else if (!ic_req) starve = 0;
   endtask

   task automatic check();
      bit e_mreq, resp, e_icv, e_dcv;
      e_mreq = act && cyc_n >= t_start && cyc_n <= t_end;
      resp   = act && cyc_n == t_resp;
      e_icv  = resp && !own_dc && ic_req;
      e_dcv  = resp && own_dc && dc_req;
      chk("mem_req", mem_req, e_mreq);
      if (e_mreq) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_we", mem_we, m_we);
         if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("ic_valid", ic_valid, e_icv);
      chk("dc_valid", dc_valid, e_dcv);
      chk("ic_stall", ic_stall, ic_req && !(resp && !own_dc));
      chk("dc_stall", dc_stall, dc_req && !(resp && own_dc));
      if (e_icv) begin
         chk("ic_rdata", ic_rdata, m_data);
         chk("ic_exc", ic_exc, m_exc);
      end
      if (e_dcv) begin
         chk("dc_rdata", dc_rdata, m_data);
         chk("dc_mexc", dc_mexc, m_exc);
      end
      if (resp) act = 1'b0;
   endtask

   task automatic cyc();
      commit();
      @(negedge clk);
      cyc_n++;
      check();
   endtask

   initial begin
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      // single fetch, zero-wait memory
      k_lat = 1; k_err = 0; k_raw = 32'h8E00C002;
      ic_addr = 32'h100; ic_req = 1'b1;
      cyc();
      chk("t1_mem_req", mem_req, 1);
      chk("t1_mem_addr", mem_addr, 32'h100);
      cyc(); cyc();
      chk("t1_ic_valid", ic_valid, 1);
      chk("t1_ic_rdata", ic_rdata, 32'h8E00C002);
      chk("t1_ic_exc", ic_exc, 0);
      ic_req = 1'b0;
      cyc();
      // simultaneous requests: dcache first, then icache
      k_raw = 32'hCAFE_0001;
      ic_addr = 32'h300; dc_addr = 32'h200; dc_we = 1'b0; ic_req = 1'b1; dc_req = 1'b1;
      cyc();
      chk("t2_first_dc", mem_addr, 32'h200);
      for (int i = 0; i < 40 && !dc_valid; i++) cyc();
      chk("t2_dc_valid", dc_valid, 1);
      dc_req = 1'b0;
      for (int i = 0; i < 40 && !mem_req; i++) cyc();
      chk("t2_then_ic", mem_addr, 32'h300);
      for (int i = 0; i < 40 && !ic_valid; i++) cyc();
      chk("t2_ic_valid", ic_valid, 1);
      ic_req = 1'b0;
      cyc(); cyc();
      // anti-starvation: dcache held high, third grant goes to icache
      ic_addr = 32'h304; ic_req = 1'b1; dc_req = 1'b1; g = 0;
      for (int i = 0; i < 80 && g < 3; i++) begin
         prev = mem_req;
         cyc();
         if (mem_req && !prev) begin ga[g] = mem_addr; g++; end
      end
      chk("t2_grant_count", g, 3);
      chk("t2_grant1", ga[0], 32'h200);
      chk("t2_grant2", ga[1], 32'h200);
      chk("t2_grant3_ic", ga[2], 32'h304);
      dc_req = 1'b0;
      for (int i = 0; i < 40 && !ic_valid; i++) cyc();
      chk("t2_ic_served", ic_valid, 1);
      ic_req = 1'b0;
      cyc();
      // store
      k_raw = 32'hDEAD_BEEF;
      dc_we = 1'b1; dc_addr = 32'h40; dc_wdata = 32'h13; dc_req = 1'b1;
      cyc();
      chk("t3_mem_we", mem_we, 1);
      chk("t3_mem_wdata", mem_wdata, 32'h13);
      chk("t3_mem_addr", mem_addr, 32'h40);
      for (int i = 0; i < 40 && !dc_valid; i++) cyc();
      chk("t3_dc_valid", dc_valid, 1);
      chk("t3_dc_rdata", dc_rdata, 0);
      chk("t3_dc_mexc", dc_mexc, 0);
      dc_req = 1'b0;
      cyc();
      // timeout with no ack at all
      k_lat = 0; dc_we = 1'b0; dc_addr = 32'h80; dc_req = 1'b1;
      cyc();
      n = 0;
      for (int i = 0; i < 40 && mem_req; i++) begin n++; cyc(); end
      chk("t4_req_cycles", n, TIMEOUT);
      chk("t4_dc_valid", dc_valid, 1);
      chk("t4_dc_mexc", dc_mexc, 1);
      dc_req = 1'b0;
      cyc();
      // fetch with memory error
      k_lat = 2; k_err = 1; k_raw = 32'h1234_5678;
      ic_addr = 32'h104; ic_req = 1'b1;
      for (int i = 0; i < 40 && !ic_valid; i++) cyc();
      chk("t5_ic_valid", ic_valid, 1);
      chk("t5_ic_exc", ic_exc, 1);
      chk("t5_ic_rdata", ic_rdata, 0);
      ic_req = 1'b0; k_err = 0;
      cyc();
      // requester gives up: access completes silently
      k_lat = 3; ic_addr = 32'h108; ic_req = 1'b1;
      cyc(); cyc();
      ic_req = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin cyc(); n += int'(ic_valid); end
      chk("drop_no_resp", n, 0);
      // reset in the middle of a wait, then a stray ack
      k_lat = 0; dc_addr = 32'h88; dc_req = 1'b1;
      cyc(); cyc(); cyc();
      chk("t6_busy", mem_req, 1);
      rst = 1'b1; dc_req = 1'b0;
      cyc();
      chk("t6_mem_req", mem_req, 0);
      chk("t6_outs", {mem_we, ic_valid, ic_exc, ic_stall, dc_valid, dc_mexc, dc_stall}, 0);
      chk("t6_mem_addr", mem_addr, 0);
      chk("t6_rdata", ic_rdata | dc_rdata | mem_wdata, 0);
      rst = 1'b0; late_ack = 1'b1;
      cyc(); cyc();
      chk("t6_late_ack", {mem_req, dc_valid, ic_valid}, 0);
      // random traffic
      k_rnd = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         cyc();
         if (ic_valid) begin ic_req = 1'($urandom_range(0, 1)); ic_addr = $urandom; end
         else if (ic_req && act && !own_dc && $urandom_range(0, 29) == 0) begin ic_req = 1'b0; ic_hold = 1'b1; end
         else if (!ic_req && !ic_hold && $urandom_range(0, 2) == 0) begin ic_req = 1'b1; ic_addr = $urandom; end
         if (dc_valid) begin
            dc_req = 1'($urandom_range(0, 1)); dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1)); dc_wdata = $urandom;
         end
         else if (dc_req && act && own_dc && $urandom_range(0, 29) == 0) begin dc_req = 1'b0; dc_hold = 1'b1; end
         else if (!dc_req && !dc_hold && $urandom_range(0, 2) == 0) begin
            dc_req = 1'b1; dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1)); dc_wdata = $urandom;
         end
         if (!act) begin ic_hold = 1'b0; dc_hold = 1'b0; end
      end
      ic_req = 1'b0; dc_req = 1'b0;
      for (int i = 0; i < 40; i++) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
